// File: rtl/mem_fill_responder.sv
// Main-memory responder serving I/D cache block fills and D write-throughs.
// Each fill streams one 16-bit word per cycle after a fixed access latency.
module mem_fill_responder #(
   parameter int DEPTH_LOG2  = 10,
   parameter int LATENCY     = 4,
   parameter int BLOCK_WORDS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        busy,
   output logic        grant_d,
   output logic [15:0] rdata,
   output logic        rdata_valid,
   output logic [2:0]  word_idx,
   output logic        done
);
   localparam int BW = DEPTH_LOG2 - 3;
   localparam int CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;
   localparam logic [2:0] LAST = 3'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {IDLE, WAIT, BURST, WRITE} state_t;

   localparam state_t FIRST = (LATENCY == 1) ? BURST : WAIT;

   state_t state_q, state_d;

   logic [15:0] mem [0:(1 << DEPTH_LOG2) - 1];
   logic [BW-1:0] blk_q, blk_d;
   logic gnt_q, gnt_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic valid_d, done_d;
   logic rd_en, wr_en, take, req_g;
   logic unused_addr;

   assign unused_addr = ^{i_addr, d_addr};
   assign req_g = gnt_q ? d_req : i_req;
   assign busy = (state_q != IDLE);
   assign grant_d = gnt_q & busy;

   always_comb begin
      state_d = state_q;
      blk_d = blk_q;
      gnt_d = gnt_q;
      cnt_d = cnt_q;
      idx_d = idx_q;
      valid_d = 1'b0;
      done_d = 1'b0;
      rd_en = 1'b0;
      wr_en = 1'b0;
      take = 1'b0;
      unique case (state_q)
         IDLE: take = 1'b1;
         WAIT: begin
            if (!req_g) state_d = IDLE;
            else if (cnt_q == 4'd0) state_d = BURST;
            else cnt_d = cnt_q - 4'd1;
         end
         BURST: begin
            // the cycle showing the final word doubles as an accept slot
            if (done) take = 1'b1;
            else if (!req_g) state_d = IDLE;
            else begin
               rd_en = 1'b1;
               valid_d = 1'b1;
               done_d = (idx_q == LAST);
               idx_d = idx_q + 3'd1;
            end
         end
         WRITE: state_d = IDLE;
      endcase
      if (take) begin
         state_d = IDLE;
         if (i_req) begin
            state_d = FIRST;
            blk_d = i_addr[DEPTH_LOG2:4];
            gnt_d = 1'b0;
            cnt_d = 4'(CNT_INIT);
            idx_d = 3'd0;
         end else if (d_req && !d_wr) begin
            state_d = FIRST;
            blk_d = d_addr[DEPTH_LOG2:4];
            gnt_d = 1'b1;
            cnt_d = 4'(CNT_INIT);
            idx_d = 3'd0;
         end else if (d_req) begin
            state_d = WRITE;
            gnt_d = 1'b1;
            wr_en = 1'b1;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         blk_q <= '0;
         gnt_q <= 1'b0;
         cnt_q <= 4'd0;
         idx_q <= 3'd0;
         rdata <= 16'd0;
         rdata_valid <= 1'b0;
         word_idx <= 3'd0;
         done <= 1'b0;
      end else begin
         state_q <= state_d;
         blk_q <= blk_d;
         gnt_q <= gnt_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         rdata_valid <= valid_d;
         done <= done_d;
         if (rd_en) begin
            rdata <= mem[{blk_q, idx_q}];
            word_idx <= idx_q;
         end
      end
   end

   // backing store is deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem[d_addr[DEPTH_LOG2:1]] <= d_wdata;
   end

endmodule

// File: tb/tb_mem_fill_responder.sv
// Bench for mem_fill_responder: timeline reference model plus
// directed literal checks and randomized two-sided requesters.
`timescale 1ns/1ps
module tb_mem_fill_responder;
   localparam int DL = 10;
   localparam int LAT = 4;
   localparam int NW = 1 << DL;

   logic clk = 1'b0;
   logic rst;
   logic i_req, d_req, d_wr;
   logic [15:0] i_addr, d_addr, d_wdata;
   logic busy, grant_d, rdata_valid, done;
   logic [15:0] rdata;
   logic [2:0] word_idx;

   logic l_i_req, l_d_req, l_d_wr;
   logic [15:0] l_i_addr, l_d_addr, l_d_wdata;
   logic l_busy, l_grant_d, l_rdata_valid, l_done;
   logic [15:0] l_rdata;
   logic [2:0] l_word_idx;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_fill_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT), .BLOCK_WORDS(8)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .busy(busy), .grant_d(grant_d), .rdata(rdata),
      .rdata_valid(rdata_valid), .word_idx(word_idx), .done(done)
   );

   mem_fill_responder #(.DEPTH_LOG2(DL), .LATENCY(1), .BLOCK_WORDS(8)) u_lat1 (
      .clk(clk), .rst(rst),
      .i_req(l_i_req), .i_addr(l_i_addr),
      .d_req(l_d_req), .d_wr(l_d_wr), .d_addr(l_d_addr), .d_wdata(l_d_wdata),
      .busy(l_busy), .grant_d(l_grant_d), .rdata(l_rdata),
      .rdata_valid(l_rdata_valid), .word_idx(l_word_idx), .done(l_done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference model: one transaction on a timeline of edge numbers.
   logic [15:0] mem_m [NW];
   bit act_m, wr_m, sd_m;
   int t0_m, e_m, base_m;
   bit x_busy, x_gnt, x_valid, x_done;
   int x_idx;
   logic [15:0] x_data;

   initial begin
      int rel;
      bit can;
      e_m = 0;
      act_m = 0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            act_m = 0;
            {x_busy, x_gnt, x_valid, x_done} = 4'b0;
         end else begin
            e_m++;
            can = !act_m;
            if (act_m) begin
               rel = e_m - t0_m;
               if (wr_m) act_m = 0;
               else if (rel == LAT + 8) begin act_m = 0; can = 1; end
               else if (!(sd_m ? d_req : i_req)) act_m = 0;
            end
            if (can) begin
               if (i_req) begin
                  act_m = 1; wr_m = 0; sd_m = 0; t0_m = e_m;
                  base_m = int'(i_addr[DL:1]) & ~7;
               end else if (d_req && !d_wr) begin
                  act_m = 1; wr_m = 0; sd_m = 1; t0_m = e_m;
                  base_m = int'(d_addr[DL:1]) & ~7;
               end else if (d_req) begin
                  act_m = 1; wr_m = 1; sd_m = 1; t0_m = e_m;
                  mem_m[int'(d_addr[DL:1])] = d_wdata;
               end
            end
            rel = e_m - t0_m;
            x_busy = act_m;
            x_gnt = act_m && sd_m;
            x_valid = act_m && !wr_m && rel >= LAT && rel < LAT + 8;
            x_done = act_m && (wr_m || rel == LAT + 7);
            if (x_valid) begin
               x_idx = rel - LAT;
               x_data = mem_m[base_m + x_idx];
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("busy", 32'(busy), 32'(x_busy));
            chk("grant_d", 32'(grant_d), 32'(x_gnt));
            chk("rdata_valid", 32'(rdata_valid), 32'(x_valid));
            chk("done", 32'(done), 32'(x_done));
            if (x_valid) begin
               chk("word_idx", 32'(word_idx), x_idx);
               chk("rdata", 32'(rdata), 32'(x_data));
            end
         end
      end
   end

   task automatic write_word(input logic [15:0] a, input logic [15:0] v);
      d_req = 1; d_wr = 1; d_addr = a; d_wdata = v;
      tick;
      chk("wr_done", 32'(done), 1);
      chk("wr_busy", 32'(busy), 1);
      chk("wr_gnt", 32'(grant_d), 1);
      chk("wr_valid", 32'(rdata_valid), 0);
      d_req = 0; d_wr = 0;
      tick;
   endtask

   task automatic fill_run(input bit side, input logic [15:0] a, input logic [15:0] w0,
                           input int ov_k, input logic [15:0] ov_v, input string tag);
      int k;
      bit fin;
      logic [15:0] xv;
      k = 0;
      fin = 0;
      if (side) begin d_req = 1; d_wr = 0; d_addr = a; end
      else begin i_req = 1; i_addr = a; end
      for (int t = 0; t < 40 && !fin; t++) begin
         tick;
         if (rdata_valid) begin
            xv = (k == ov_k) ? ov_v : w0 + 16'(k);
            chk({tag, "_idx"}, 32'(word_idx), k);
            chk({tag, "_edge"}, t, LAT + k);
            chk({tag, "_data"}, 32'(rdata), 32'(xv));
            chk({tag, "_gnt"}, 32'(grant_d), 32'(side));
            if (done) begin
               chk({tag, "_last"}, k, 7);
               fin = 1;
               if (side) d_req = 0;
               else i_req = 0;
            end
            k++;
         end
      end
      if (!fin) begin
         chk({tag, "_timeout"}, 0, 1);
         i_req = 0;
         d_req = 0;
      end
      tick;
      chk({tag, "_idle"}, 32'(busy), 0);
   endtask

   function automatic logic [15:0] pre_val(input int w);
      if (w >= 16'h10 && w <= 16'h17) return 16'hA000 + 16'(w - 16'h10);
      if (w >= 16'h20 && w <= 16'h27) return 16'hC000 + 16'(w - 16'h20);
      if (w >= 16'h08 && w <= 16'h0F) return 16'h5A00 + 16'(w - 16'h08);
      return 16'($urandom);
   endfunction

   initial begin
      int first_i, first_d;
      bit fin;
      rst = 1;
      {i_req, d_req, d_wr} = 3'b0;
      {i_addr, d_addr, d_wdata} = 48'h0;
      {l_i_req, l_d_req, l_d_wr} = 3'b0;
      {l_i_addr, l_d_addr, l_d_wdata} = 48'h0;
      repeat (2) tick;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_gnt", 32'(grant_d), 0);
      chk("rst_valid", 32'(rdata_valid), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rdata", 32'(rdata), 0);
      rst = 0;

      for (int w = 0; w < NW; w++) write_word(16'(w << 1), pre_val(w));

      fill_run(0, 16'h0024, 16'hA000, -1, 16'h0, "ifill");

      write_word(16'h0046, 16'hBEEF);
      fill_run(1, 16'h0040, 16'hC000, 3, 16'hBEEF, "dfill");

      // simultaneous I and D fills
      first_i = -1; first_d = -1;
      i_req = 1; i_addr = 16'h0024;
      d_req = 1; d_wr = 0; d_addr = 16'h0010;
      for (int t = 0; t < 60 && (i_req || d_req); t++) begin
         tick;
         if (rdata_valid && word_idx == 3'd0) begin
            if (grant_d) first_d = t;
            else first_i = t;
         end
         if (done && !grant_d) i_req = 0;
         if (done && grant_d) d_req = 0;
      end
      chk("sim_first_i", first_i, 4);
      chk("sim_first_d", first_d, 16);
      i_req = 0; d_req = 0;
      tick;

      // abort of I while D waits
      i_req = 1; i_addr = 16'h0024;
      d_req = 1; d_wr = 0; d_addr = 16'h0040;
      tick;
      repeat (5) tick;
      i_req = 0;
      tick;
      chk("abort_valid", 32'(rdata_valid), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_done", 32'(done), 0);
      tick;
      chk("abort_d_busy", 32'(busy), 1);
      chk("abort_d_gnt", 32'(grant_d), 1);
      fin = 0;
      for (int t = 0; t < 30 && !fin; t++) begin
         tick;
         if (done && grant_d) begin d_req = 0; fin = 1; end
      end
      chk("abort_d_done", 32'(fin), 1);
      tick;

      // async reset during word 3
      i_req = 1; i_addr = 16'h0024;
      tick;
      repeat (7) tick;
      chk("pre_rst_idx", 32'(word_idx), 3);
      chk("pre_rst_data", 32'(rdata), 32'h0000A003);
      #2 rst = 1;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_gnt", 32'(grant_d), 0);
      chk("arst_valid", 32'(rdata_valid), 0);
      chk("arst_done", 32'(done), 0);
      chk("arst_idx", 32'(word_idx), 0);
      chk("arst_rdata", 32'(rdata), 0);
      #3 rst = 0;
      fill_run(0, 16'h0024, 16'hA000, -1, 16'h0, "post_rst");

      fill_run(0, 16'h0810, 16'h5A00, -1, 16'h0, "wrap_hi");
      fill_run(0, 16'h0010, 16'h5A00, -1, 16'h0, "wrap_lo");

      // single-cycle latency instance
      l_d_req = 1; l_d_wr = 1; l_d_addr = 16'h0060; l_d_wdata = 16'h1234;
      tick;
      chk("l1_wr_done", 32'(l_done), 1);
      l_d_req = 0; l_d_wr = 0;
      tick;
      l_i_req = 1; l_i_addr = 16'h0060;
      tick;
      chk("l1_t0_busy", 32'(l_busy), 1);
      chk("l1_t0_valid", 32'(l_rdata_valid), 0);
      tick;
      chk("l1_t1_valid", 32'(l_rdata_valid), 1);
      chk("l1_t1_idx", 32'(l_word_idx), 0);
      chk("l1_t1_data", 32'(l_rdata), 32'h1234);
      l_i_req = 0;
      tick;
      chk("l1_abort_valid", 32'(l_rdata_valid), 0);
      chk("l1_abort_busy", 32'(l_busy), 0);

      // randomized requesters
      for (int c = 0; c < 4000; c++) begin
         if (i_req) begin
            if (done && !grant_d) i_req = 0;
            else if ($urandom_range(0, 99) < 2) i_req = 0;
         end else if ($urandom_range(0, 99) < 25) begin
            i_req = 1;
            i_addr = 16'($urandom);
         end
         if (d_req) begin
            if (done && grant_d) d_req = 0;
            else if (!d_wr && $urandom_range(0, 99) < 2) d_req = 0;
         end else if ($urandom_range(0, 99) < 25) begin
            d_req = 1;
            d_wr = ($urandom_range(0, 2) == 0);
            d_addr = 16'($urandom);
            d_wdata = 16'($urandom);
         end
         tick;
      end
      i_req = 0;
      d_req = 0;
      repeat (20) tick;
      chk("end_idle", 32'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
